// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared offsets, status bit positions and I/O window base for dmem_mmio_ctrl
package dmem_pkg;

    localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_FF00;

    localparam logic [7:0] TXDATA_OFS = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h04;
    localparam logic [7:0] CYCLE_OFS  = 8'h08;

    localparam int STAT_OVF_BIT   = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_EMPTY_BIT = 10;

endpackage

// File: rtl/tx_sync_fifo.sv
// rtl/tx_sync_fifo.sv - parameterised synchronous FIFO with async active-low reset
module tx_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// rtl/dmem_mmio_ctrl.sv - data RAM plus MMIO TX FIFO/status window; DMEM_CYCLE_CNT_EN adds a cycle counter
module dmem_mmio_ctrl
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [MEM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          io_sel;
    logic [7:0]    ofs;
    logic          push;
    logic          pop;
    logic          ovf;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_lsb;

    assign io_sel     = (aluout[31:8] == IO_BASE[31:8]);
    assign ofs        = {aluout[7:2], 2'b00};
    assign ram_idx    = aluout[AW+1:2];
    assign unused_lsb = ^aluout[1:0];

    assign push      = memwrite && io_sel && (ofs == TXDATA_OFS);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (memwrite && !io_sel) ram[ram_idx] <= writedata;
    end

    tx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .din   (writedata),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Overflow only latches when the pushed word is actually dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf <= 1'b1;
        end else if (memwrite && io_sel && (ofs == STATUS_OFS) && writedata[STAT_OVF_BIT]) begin
            ovf <= 1'b0;
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else if (memwrite && io_sel && (ofs == CYCLE_OFS)) begin
            cycle_cnt <= writedata;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        readdata = '0;
        if (io_sel) begin
            if (ofs == STATUS_OFS) begin
                readdata[7:0]          = 8'(fifo_count);
                readdata[STAT_OVF_BIT]   = ovf;
                readdata[STAT_FULL_BIT]  = fifo_full;
                readdata[STAT_EMPTY_BIT] = fifo_empty;
            end
`ifdef DMEM_CYCLE_CNT_EN
            if (ofs == CYCLE_OFS) readdata = cycle_cnt;
`endif
        end else begin
            readdata = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// tb/tb_dmem_mmio_ctrl.sv - randomized self-checking bench for dmem_mmio_ctrl against a queue-based model
module tb_dmem_mmio_ctrl;

    localparam int          MW  = 64;
    localparam int          FD  = 4;
    localparam logic [31:0] IOB = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] aluout = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] mq [$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_ram [MW];
`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] m_cyc = '0;
`endif

    always #5 clk = ~clk;

    dmem_mmio_ctrl #(
        .MEM_WORDS  (MW),
        .FIFO_DEPTH (FD),
        .IO_BASE    (IOB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic is_io(input logic [31:0] a);
        return (a[31:8] == IOB[31:8]);
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        int ofs;
        int n;
        ofs = int'(a[7:0]) / 4 * 4;
        n = mq.size();
        if (is_io(a)) begin
            if (ofs == 4) return (n == 0 ? 32'h400 : 32'h0) | (n == FD ? 32'h200 : 32'h0)
                               | (m_ovf ? 32'h100 : 32'h0) | 32'(n);
`ifdef DMEM_CYCLE_CNT_EN
            if (ofs == 8) return m_cyc;
`endif
            return 32'h0;
        end
        return m_ram[(a / 4) % MW];
    endfunction

    function automatic logic [31:0] m_head();
        return (mq.size() == 0) ? 32'h0 : mq[0];
    endfunction

    task automatic m_reset();
        mq.delete();
        m_ovf = 1'b0;
`ifdef DMEM_CYCLE_CNT_EN
        m_cyc = '0;
`endif
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        memwrite  = we;
        aluout    = a;
        writedata = wd;
        out_ready = rdy;
        #1;
    endtask

    task automatic tick();
        logic popped;
        int   ofs;
        @(posedge clk);
        if (reset) begin
            ofs    = int'(aluout[7:0]) / 4 * 4;
            popped = (mq.size() != 0) && out_ready;
            if (memwrite && !is_io(aluout)) m_ram[(aluout / 4) % MW] = writedata;
            if (memwrite && is_io(aluout) && ofs == 0) begin
                if (mq.size() == FD && !popped) m_ovf = 1'b1;
                else mq.push_back(writedata);
            end
            if (popped) void'(mq.pop_front());
            if (memwrite && is_io(aluout) && ofs == 4 && writedata[8]) m_ovf = 1'b0;
`ifdef DMEM_CYCLE_CNT_EN
            if (memwrite && is_io(aluout) && ofs == 8) m_cyc = writedata;
            else m_cyc = m_cyc + 32'd1;
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, IOB | 32'h4, 32'h0, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        total++;
        if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got %h want 0", out_data); end
        total++;
        if (readdata !== 32'h400) begin bad++; $display("FAIL reset_status got %h want 00000400", readdata); end
        @(negedge clk);
        m_reset();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_ram();
        logic [31:0] a;
        for (int i = 0; i < MW; i++) begin
            drive(1'b1, 32'(i * 4), $urandom, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        tick();
        drive(1'b0, 32'h10, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_0x10 got %h want deadbeef", readdata); end
        drive(1'b0, 32'h10 + MW * 4, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_alias got %h want deadbeef", readdata); end
        drive(1'b0, 32'h13, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_0x13 got %h want deadbeef", readdata); end
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            if (is_io(a)) a[31] = 1'b0;
            drive(1'b0, a, 32'h0, 1'b0);
            total++;
            if (readdata !== m_rd(a)) begin bad++; $display("FAIL ram_rand addr=%h got %h want %h", a, readdata, m_rd(a)); end
        end
    endtask

    task automatic test_tx_drain();
        logic [31:0] exp [3];
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
        drive(1'b1, IOB, 32'h11, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL no_bypass got %b want 0", out_valid); end
        tick();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL push_latency got %b want 1", out_valid); end
        drive(1'b1, IOB, 32'h22, 1'b0); tick();
        drive(1'b1, IOB, 32'h33, 1'b0); tick();
        drive(1'b0, IOB | 32'h4, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'h3) begin bad++; $display("FAIL drain_status got %h want 00000003", readdata); end
        drive(1'b0, IOB, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL txdata_load got %h want 0", readdata); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h11) begin
                bad++; $display("FAIL hold_stable got %b/%h want 1/00000011", out_valid, out_data);
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, IOB | 32'h4, 32'h0, 1'b1);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[k]) begin
                bad++; $display("FAIL drain_%0d got %b/%h want 1/%h", k, out_valid, out_data, exp[k]);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || readdata !== 32'h400) begin
            bad++; $display("FAIL drain_empty got %b/%h want 0/00000400", out_valid, readdata);
        end
    endtask

    task automatic test_overflow(output logic [31:0] w [5]);
        for (int i = 0; i < 5; i++) begin
            w[i] = $urandom;
            drive(1'b1, IOB, w[i], 1'b0);
            tick();
        end
        drive(1'b0, IOB | 32'h4, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'h304) begin bad++; $display("FAIL ovf_status got %h want 00000304", readdata); end
        drive(1'b1, IOB | 32'h4, 32'h100, 1'b0);
        tick();
        drive(1'b0, IOB | 32'h4, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'h204) begin bad++; $display("FAIL ovf_clear got %h want 00000204", readdata); end
        total++;
        if (out_data !== w[0]) begin bad++; $display("FAIL ovf_head got %h want %h", out_data, w[0]); end
    endtask

    task automatic test_full_push_pop(input logic [31:0] w [5]);
        logic [31:0] exp [4];
        exp[0] = w[1]; exp[1] = w[2]; exp[2] = w[3]; exp[3] = 32'h55;
        drive(1'b1, IOB, 32'h55, 1'b1);
        total++;
        if (out_data !== w[0]) begin bad++; $display("FAIL fpp_head got %h want %h", out_data, w[0]); end
        tick();
        drive(1'b0, IOB | 32'h4, 32'h0, 1'b1);
        total++;
        if (readdata !== 32'h204) begin bad++; $display("FAIL fpp_status got %h want 00000204", readdata); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[k]) begin
                bad++; $display("FAIL fpp_drain_%0d got %b/%h want 1/%h", k, out_valid, out_data, exp[k]);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, IOB, $urandom, 1'b0);
            tick();
        end
        drive(1'b0, IOB | 32'h4, 32'h0, 1'b1);
        tick();
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++; $display("FAIL rst_mid got %b/%h want 0/00000000", out_valid, out_data);
        end
        total++;
        if (readdata !== 32'h400) begin bad++; $display("FAIL rst_mid_status got %h want 00000400", readdata); end
        tick();
        tick();
        reset = 1'b1;
        drive(1'b1, IOB, 32'h77, 1'b0);
        tick();
        drive(1'b0, IOB | 32'h4, 32'h0, 1'b1);
        total++;
        if (out_data !== 32'h77 || readdata !== 32'h1) begin
            bad++; $display("FAIL rst_first got %h/%h want 00000077/00000001", out_data, readdata);
        end
        tick();
    endtask

    task automatic test_cycle();
        drive(1'b0, IOB | 32'hC, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL unmapped got %h want 0", readdata); end
`ifdef DMEM_CYCLE_CNT_EN
        drive(1'b1, IOB | 32'h8, 32'hFFFF_FFFE, 1'b0);
        tick();
        drive(1'b0, IOB | 32'h8, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cyc0 got %h want fffffffe", readdata); end
        tick();
        total++;
        if (readdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cyc1 got %h want ffffffff", readdata); end
        tick();
        total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL cyc2 got %h want 00000000", readdata); end
`else
        drive(1'b1, IOB | 32'h8, 32'h1234_5678, 1'b0);
        tick();
        drive(1'b0, IOB | 32'h8, 32'h0, 1'b0);
        total++;
        if (readdata !== 32'h0) begin bad++; $display("FAIL cyc_off got %h want 0", readdata); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        int          op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            wd = $urandom;
            a  = $urandom;
            if (is_io(a)) a[31] = 1'b0;
            we = 1'b0;
            case (op)
                0, 1, 2: we = 1'b1;
                3, 4:    we = 1'b0;
                5, 6:    begin we = 1'b1; a = IOB; end
                7:       a = IOB | 32'h4;
                8:       begin we = 1'b1; a = IOB | 32'h4; end
                default: a = IOB | 32'(4 * $urandom_range(2, 63));
            endcase
            drive(we, a, wd, 1'($urandom_range(0, 1)));
            total++;
            if (readdata !== m_rd(a)) begin bad++; $display("FAIL rand_rd i=%0d addr=%h got %h want %h", i, a, readdata, m_rd(a)); end
            total++;
            if (out_valid !== (mq.size() != 0) || out_data !== m_head()) begin
                bad++; $display("FAIL rand_out i=%0d got %b/%h want %b/%h", i, out_valid, out_data, mq.size() != 0, m_head());
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] w [5];
        #12;
        test_reset();
        test_ram();
        test_tx_drain();
        test_overflow(w);
        test_full_push_pop(w);
        test_reset_mid_drain();
        test_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
